// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access controller.
// Size decoding and alignment rules live here so the controller and the MEM mux agree on them.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of byte beats needed for an access of the given size.
  function automatic logic [2:0] beat_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_WORD: n = 3'd4;
      SZ_HALF: n = 3'd2;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment, size 11 is never legal.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lsb[0];
      SZ_WORD: ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_load_extend.sv
// Load extension: turns the byte accumulator into a 32-bit write-back value.
// Purely combinational so the MEM write-back mux can share it.
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [1:0]  size,
  input  logic        se,
  output logic [31:0] data
);

  always_comb begin
    data = acc;
    case (size)
      SZ_BYTE: data = se ? {{24{acc[7]}}, acc[7:0]} : {24'd0, acc[7:0]};
      SZ_HALF: data = se ? {{16{acc[15]}}, acc[15:0]} : {16'd0, acc[15:0]};
      default: data = acc;
    endcase
  end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage controller: splits loads/stores into big-endian byte beats and stalls the pipeline.
// Optional ack-timeout abort with bus_err output is built when MEMCTRL_TIMEOUT_EN is defined.
module mem_stage_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
`ifdef MEMCTRL_TIMEOUT_EN
  output logic              bus_err,
`endif
  output logic              align_err
);

  state_t            state_reg;
  logic [2:0]        beat_reg;
  logic [2:0]        nbeats_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [1:0]        size_reg;
  logic              se_reg;
  logic              write_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       acc_reg;

  logic [31:0]       acc_next;
  logic [31:0]       ext_data;
  logic              req_aligned;
  logic              last_beat;

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WAIT_W-1:0] wait_reg;
`endif

  // Beats go out most significant byte first, so beat k of n carries byte n-1-k.
  function automatic logic [7:0] store_byte(input logic [31:0] w, input logic [2:0] nb,
                                            input logic [2:0] bt);
    logic [1:0] idx;
    logic [7:0] b;
    idx = 2'(nb - bt - 3'd1);
    case (idx)
      2'd3:    b = w[31:24];
      2'd2:    b = w[23:16];
      2'd1:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign req_aligned = is_aligned(req_size, req_addr[1:0]);
  assign acc_next    = {acc_reg[23:0], mem_rdata};
  assign last_beat   = (beat_reg == nbeats_reg - 3'd1);

  assign stall     = ~R & (((state_reg == IDLE) & req_valid & req_aligned) | (state_reg == XFER));
  assign align_err = ~R & (state_reg == IDLE) & req_valid & ~req_aligned;

  load_extend u_load_extend (
    .acc  (acc_next),
    .size (size_reg),
    .se   (se_reg),
    .data (ext_data)
  );

  always_ff @(posedge Clk) begin
    if (R) begin
      state_reg  <= IDLE;
      beat_reg   <= 3'd0;
      nbeats_reg <= 3'd1;
      base_reg   <= '0;
      size_reg   <= SZ_BYTE;
      se_reg     <= 1'b0;
      write_reg  <= 1'b0;
      wdata_reg  <= 32'd0;
      acc_reg    <= 32'd0;
      load_data  <= 32'd0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
`ifdef MEMCTRL_TIMEOUT_EN
      wait_reg   <= '0;
      bus_err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (req_valid && req_aligned) begin
            base_reg   <= req_addr;
            size_reg   <= req_size;
            se_reg     <= req_se;
            write_reg  <= req_write;
            wdata_reg  <= req_wdata;
            beat_reg   <= 3'd0;
            nbeats_reg <= beat_count(req_size);
            acc_reg    <= 32'd0;
            mem_req    <= 1'b1;
            mem_we     <= req_write;
            mem_addr   <= req_addr;
            mem_wdata  <= store_byte(req_wdata, beat_count(req_size), 3'd0);
            state_reg  <= XFER;
`ifdef MEMCTRL_TIMEOUT_EN
            wait_reg   <= '0;
`endif
          end
        end

        XFER: begin
          if (mem_ack) begin
            acc_reg  <= acc_next;
            beat_reg <= beat_reg + 3'd1;
`ifdef MEMCTRL_TIMEOUT_EN
            wait_reg <= '0;
`endif
            if (last_beat) begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              done      <= 1'b1;
              state_reg <= RESP;
              if (!write_reg) begin
                load_data <= ext_data;
              end
            end else begin
              mem_addr  <= base_reg + ADDR_W'(beat_reg + 3'd1);
              mem_wdata <= store_byte(wdata_reg, nbeats_reg, beat_reg + 3'd1);
            end
          end
`ifdef MEMCTRL_TIMEOUT_EN
          // The counter would hit TIMEOUT_CYC-1 on this edge: abandon the remaining beats.
          else if (wait_reg == WAIT_W'(TIMEOUT_CYC - 2)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            load_data <= 32'd0;
            state_reg <= RESP;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
`endif
        end

        RESP: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Directed bench for mem_stage_access_ctrl with a byte-wide behavioural memory.
// Each task issues one scenario, traces it cycle by cycle and checks against hand values.
module tb_mem_stage_access_ctrl;

  logic        Clk;
  logic        R;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_se;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        align_err;
`ifdef MEMCTRL_TIMEOUT_EN
  logic        bus_err;
`endif

  logic        ack_en;
  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;

  // Per-cycle trace, index = cycle number counted from the request cycle (1).
  logic       tr_stall [0:31];
  logic       tr_req   [0:31];
  logic       tr_we    [0:31];
  logic [7:0] tr_addr  [0:31];
  logic [7:0] tr_wdata [0:31];
  logic       tr_done  [0:31];
  logic       tr_aerr  [0:31];
  logic       ack_mask [0:31];
  logic       rst_mask [0:31];
  int         done_cyc;

  mem_stage_access_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
    .Clk       (Clk),
    .R         (R),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_size  (req_size),
    .req_se    (req_se),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .done      (done),
    .load_data (load_data),
`ifdef MEMCTRL_TIMEOUT_EN
    .bus_err   (bus_err),
`endif
    .align_err (align_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req & ack_en;

  always @(posedge Clk) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic clear_masks();
    for (int i = 0; i < 32; i++) begin
      ack_mask[i] = 1'b1;
      rst_mask[i] = 1'b0;
    end
  endtask

  // Called at posedge+1: presents the request for exactly one cycle.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic se,
                       input logic [7:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_se    = se;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic capture(input int ncyc);
    done_cyc = 0;
    for (int c = 1; c <= ncyc; c++) begin
      ack_en = ack_mask[c];
      R      = rst_mask[c];
      @(negedge Clk);
      tr_stall[c] = stall;
      tr_req[c]   = mem_req;
      tr_we[c]    = mem_we;
      tr_addr[c]  = mem_addr;
      tr_wdata[c] = mem_wdata;
      tr_done[c]  = done;
      tr_aerr[c]  = align_err;
      if (done && done_cyc == 0) done_cyc = c;
      @(posedge Clk);
      #1;
      req_valid = 1'b0;
    end
    R      = 1'b0;
    ack_en = 1'b1;
  endtask

  task automatic test_reset();
    R = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 8'h00, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    req_addr = 8'h02;
    #1;
    checks++;
    if (align_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_align_err: got %b expected 0", align_err);
    end
    @(posedge Clk);
    #1;
    checks++;
    if ({mem_req, mem_we, done} !== 3'b000 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 ||
        load_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: req=%b we=%b done=%b addr=%h wdata=%h ld=%h expected all zero",
               mem_req, mem_we, done, mem_addr, mem_wdata, load_data);
    end
    req_valid = 1'b0;
    R = 1'b0;
    @(posedge Clk);
    #1;
    $display("reset: checked forced stall/align_err and cleared registers");
  endtask

  task automatic test_word_load();
    mem[8'h04] = 8'h12; mem[8'h05] = 8'h34; mem[8'h06] = 8'h56; mem[8'h07] = 8'h78;
    clear_masks();
    issue(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
    capture(7);
    checks++;
    if (done_cyc !== 6) begin
      errors++;
      $display("FAIL word_load_latency: done in cycle %0d expected 6", done_cyc);
    end
    checks++;
    if (load_data !== 32'h12345678) begin
      errors++;
      $display("FAIL word_load_data: got %h expected 12345678", load_data);
    end
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (tr_req[c] !== 1'b1 || tr_we[c] !== 1'b0 || tr_addr[c] !== 8'(8'h04 + c - 2)) begin
        errors++;
        $display("FAIL word_load_beat%0d: req=%b we=%b addr=%h expected req=1 we=0 addr=%h",
                 c - 2, tr_req[c], tr_we[c], tr_addr[c], 8'(8'h04 + c - 2));
      end
    end
    checks++;
    if ({tr_stall[1], tr_stall[2], tr_stall[3], tr_stall[4], tr_stall[5], tr_stall[6]} !== 6'b111110) begin
      errors++;
      $display("FAIL word_load_stall: cycles1-6 %b%b%b%b%b%b expected 111110", tr_stall[1],
               tr_stall[2], tr_stall[3], tr_stall[4], tr_stall[5], tr_stall[6]);
    end
    checks++;
    if (tr_req[1] !== 1'b0 || tr_req[6] !== 1'b0 || tr_done[7] !== 1'b0) begin
      errors++;
      $display("FAIL word_load_edges: req c1=%b c6=%b done c7=%b expected 0 0 0",
               tr_req[1], tr_req[6], tr_done[7]);
    end
    $display("word_load @04: done cycle %0d data %h", done_cyc, load_data);
  endtask

  task automatic test_byte_load();
    mem[8'h09] = 8'h85;
    clear_masks();
    issue(1'b0, 2'b00, 1'b1, 8'h09, 32'h0);
    capture(4);
    checks++;
    if (done_cyc !== 3 || load_data !== 32'hFFFFFF85 || tr_addr[2] !== 8'h09) begin
      errors++;
      $display("FAIL byte_load_se: done=%0d data=%h addr=%h expected 3 FFFFFF85 09",
               done_cyc, load_data, tr_addr[2]);
    end
    $display("byte_load se=1 @09: data %h", load_data);
    issue(1'b0, 2'b00, 1'b0, 8'h09, 32'h0);
    capture(4);
    checks++;
    if (done_cyc !== 3 || load_data !== 32'h00000085) begin
      errors++;
      $display("FAIL byte_load_ze: done=%0d data=%h expected 3 00000085", done_cyc, load_data);
    end
    $display("byte_load se=0 @09: data %h", load_data);
  endtask

  task automatic test_half_store();
    mem[8'h0A] = 8'h00; mem[8'h0B] = 8'h00;
    clear_masks();
    issue(1'b1, 2'b01, 1'b0, 8'h0A, 32'hDEADBEEF);
    capture(5);
    checks++;
    if (mem[8'h0A] !== 8'hBE || mem[8'h0B] !== 8'hEF) begin
      errors++;
      $display("FAIL half_store_mem: [0A]=%h [0B]=%h expected BE EF", mem[8'h0A], mem[8'h0B]);
    end
    checks++;
    if (tr_we[2] !== 1'b1 || tr_wdata[2] !== 8'hBE || tr_wdata[3] !== 8'hEF || tr_addr[3] !== 8'h0B) begin
      errors++;
      $display("FAIL half_store_beats: we=%b wd=%h,%h addr2=%h expected 1 BE,EF 0B",
               tr_we[2], tr_wdata[2], tr_wdata[3], tr_addr[3]);
    end
    checks++;
    if (done_cyc !== 4 || load_data !== 32'h00000085) begin
      errors++;
      $display("FAIL half_store_done: done=%0d data=%h expected 4 00000085", done_cyc, load_data);
    end
    $display("half_store DEADBEEF @0A: mem %h %h", mem[8'h0A], mem[8'h0B]);
  endtask

  task automatic test_word_store_reload();
    clear_masks();
    issue(1'b1, 2'b10, 1'b0, 8'h10, 32'hA1B2C3D4);
    capture(7);
    checks++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hA1B2C3D4 || done_cyc !== 6) begin
      errors++;
      $display("FAIL word_store: mem %h%h%h%h done=%0d expected A1B2C3D4 6",
               mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13], done_cyc);
    end
    issue(1'b0, 2'b01, 1'b1, 8'h10, 32'h0);
    capture(5);
    checks++;
    if (load_data !== 32'hFFFFA1B2) begin
      errors++;
      $display("FAIL half_load_se: got %h expected FFFFA1B2", load_data);
    end
    issue(1'b0, 2'b01, 1'b0, 8'h12, 32'h0);
    capture(5);
    checks++;
    if (load_data !== 32'h0000C3D4) begin
      errors++;
      $display("FAIL half_load_ze: got %h expected 0000C3D4", load_data);
    end
    $display("word_store A1B2C3D4 @10 then halfword reloads: last %h", load_data);
  endtask

  task automatic test_misaligned();
    logic [1:0] sz [0:2];
    logic [7:0] ad [0:2];
    sz[0] = 2'b10; ad[0] = 8'h06;
    sz[1] = 2'b11; ad[1] = 8'h00;
    sz[2] = 2'b01; ad[2] = 8'h0B;
    clear_masks();
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, sz[k], 1'b0, ad[k], 32'h0);
      capture(3);
      checks++;
      if (tr_aerr[1] !== 1'b1 || tr_stall[1] !== 1'b0 || tr_req[2] !== 1'b0 ||
          tr_req[3] !== 1'b0 || done_cyc !== 0) begin
        errors++;
        $display("FAIL misaligned_%0d: aerr=%b stall=%b req=%b%b done=%0d expected 1 0 00 0",
                 k, tr_aerr[1], tr_stall[1], tr_req[2], tr_req[3], done_cyc);
      end
      $display("misaligned size=%b addr=%h: align_err %b", sz[k], ad[k], tr_aerr[1]);
    end
  endtask

  task automatic test_wait_states();
    mem[8'h20] = 8'hCA; mem[8'h21] = 8'hFE; mem[8'h22] = 8'hBA; mem[8'h23] = 8'hBE;
    clear_masks();
    ack_mask[4] = 1'b0;
    ack_mask[5] = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
    capture(9);
    checks++;
    if (done_cyc !== 8 || load_data !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL wait_done: done=%0d data=%h expected 8 CAFEBABE", done_cyc, load_data);
    end
    checks++;
    if (tr_addr[4] !== 8'h22 || tr_addr[5] !== 8'h22 || tr_addr[6] !== 8'h22 ||
        tr_req[5] !== 1'b1 || tr_stall[5] !== 1'b1 || tr_stall[7] !== 1'b1 || tr_stall[8] !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold: addr %h %h %h req5=%b stall5,7,8=%b%b%b expected 22 22 22 1 110",
               tr_addr[4], tr_addr[5], tr_addr[6], tr_req[5], tr_stall[5], tr_stall[7], tr_stall[8]);
    end
    $display("word_load with 2 waits @20: done cycle %0d data %h", done_cyc, load_data);
  endtask

  task automatic test_reset_mid_xfer();
    clear_masks();
    rst_mask[3] = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
    capture(7);
    checks++;
    if (tr_stall[3] !== 1'b0 || tr_req[4] !== 1'b0 || tr_stall[4] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_xfer: stall3=%b req4=%b stall4=%b expected 0 0 0",
               tr_stall[3], tr_req[4], tr_stall[4]);
    end
    checks++;
    if (done_cyc !== 0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_xfer_done: done=%0d data=%h expected 0 00000000", done_cyc, load_data);
    end
    $display("reset mid word load: returned to idle, data %h", load_data);
  endtask

  task automatic test_back_to_back();
    clear_masks();
    issue(1'b0, 2'b00, 1'b0, 8'h04, 32'h0);
    capture(3);
    checks++;
    if (done_cyc !== 3 || load_data !== 32'h00000012) begin
      errors++;
      $display("FAIL b2b_first: done=%0d data=%h expected 3 00000012", done_cyc, load_data);
    end
    issue(1'b0, 2'b00, 1'b0, 8'h05, 32'h0);
    capture(3);
    checks++;
    if (done_cyc !== 3 || load_data !== 32'h00000034 || tr_stall[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: done=%0d data=%h stall=%b expected 3 00000034 1",
               done_cyc, load_data, tr_stall[1]);
    end
    $display("back_to_back byte loads @04,@05: data %h", load_data);
  endtask

`ifdef MEMCTRL_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc;
    clear_masks();
    for (int c = 0; c < 32; c++) ack_mask[c] = 1'b0;
    err_cyc = 0;
    issue(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
    fork
      capture(19);
      begin
        for (int c = 1; c <= 19; c++) begin
          @(negedge Clk);
          if (bus_err && err_cyc == 0) err_cyc = c;
        end
      end
    join
    checks++;
    if (done_cyc !== 17 || err_cyc !== 17 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL timeout: done=%0d bus_err=%0d data=%h expected 17 17 00000000",
               done_cyc, err_cyc, load_data);
    end
    $display("timeout word load: bus_err cycle %0d", err_cyc);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    R = 1'b1;
    ack_en = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_se = 1'b0;
    req_addr = 8'h00;
    req_wdata = 32'h0;
    @(posedge Clk);
    #1;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_word_store_reload();
    test_misaligned();
    test_wait_states();
    test_word_load();
    test_reset_mid_xfer();
    test_back_to_back();
`ifdef MEMCTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
